// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - BCD time-of-day counter with 12/24-hour display and synchronised set buttons
// Optional alarm comparator is compiled in when ALARM_EN is defined.
module bcd_time_counter #(
    parameter int TICK_DIV    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick,
    input  logic       hold,
    input  logic       mode12,
    input  logic       inc_min,
    input  logic       inc_hr,
`ifdef ALARM_EN
    input  logic       alarm_on,
    input  logic [7:0] alarm_hr,
    input  logic [7:0] alarm_min,
    output logic       alarm,
`endif
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hr,
    output logic       pm,
    output logic       day
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    logic [7:0]             r_h24;
    logic [7:0]             r_m;
    logic [7:0]             r_s;
    logic [PW-1:0]          r_pcnt;
    logic                   r_day;
    logic [SYNC_STAGES-1:0] r_min_sync;
    logic [SYNC_STAGES-1:0] r_hr_sync;
    logic                   r_min_dly;
    logic                   r_hr_dly;

    logic                   w_min_edge;
    logic                   w_hr_edge;
    logic                   w_tick_ok;
    logic                   w_adv;
    logic [7:0]             w_hr12;

    function automatic logic [7:0] inc_bcd60(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5)
                r = 8'h00;
            else
                r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] inc_bcd24(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h23)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Edge detect compares the last synchroniser stage against its one-cycle-delayed copy.
    assign w_min_edge = r_min_sync[SYNC_STAGES-1] & ~r_min_dly;
    assign w_hr_edge  = r_hr_sync[SYNC_STAGES-1]  & ~r_hr_dly;
    assign w_tick_ok  = tick & ~hold & ~w_min_edge & ~w_hr_edge;
    assign w_adv      = w_tick_ok & (r_pcnt == P_LAST);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_min_sync <= '1;
            r_hr_sync  <= '1;
            r_min_dly  <= 1'b1;
            r_hr_dly   <= 1'b1;
        end else begin
            r_min_sync <= {r_min_sync[SYNC_STAGES-2:0], inc_min};
            r_hr_sync  <= {r_hr_sync[SYNC_STAGES-2:0], inc_hr};
            r_min_dly  <= r_min_sync[SYNC_STAGES-1];
            r_hr_dly   <= r_hr_sync[SYNC_STAGES-1];
        end
    end

    // Button edges and accepted ticks are mutually exclusive, so the branches never collide.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_h24  <= 8'h00;
            r_m    <= 8'h00;
            r_s    <= 8'h00;
            r_pcnt <= '0;
            r_day  <= 1'b0;
        end else begin
            r_day <= 1'b0;
            if (w_min_edge) begin
                r_m    <= inc_bcd60(r_m);
                r_s    <= 8'h00;
                r_pcnt <= '0;
            end
            if (w_hr_edge)
                r_h24 <= inc_bcd24(r_h24);
            if (w_tick_ok) begin
                if (w_adv) begin
                    r_pcnt <= '0;
                    r_s    <= inc_bcd60(r_s);
                    if (r_s == 8'h59) begin
                        r_m <= inc_bcd60(r_m);
                        if (r_m == 8'h59) begin
                            r_h24 <= inc_bcd24(r_h24);
                            if (r_h24 == 8'h23)
                                r_day <= 1'b1;
                        end
                    end
                end else begin
                    r_pcnt <= r_pcnt + PW'(1);
                end
            end
        end
    end

    always_comb begin
        w_hr12 = r_h24;
        case (r_h24)
            8'h00:   w_hr12 = 8'h12;
            8'h13:   w_hr12 = 8'h01;
            8'h14:   w_hr12 = 8'h02;
            8'h15:   w_hr12 = 8'h03;
            8'h16:   w_hr12 = 8'h04;
            8'h17:   w_hr12 = 8'h05;
            8'h18:   w_hr12 = 8'h06;
            8'h19:   w_hr12 = 8'h07;
            8'h20:   w_hr12 = 8'h08;
            8'h21:   w_hr12 = 8'h09;
            8'h22:   w_hr12 = 8'h10;
            8'h23:   w_hr12 = 8'h11;
            default: w_hr12 = r_h24;
        endcase
    end

    assign sec = r_s;
    assign min = r_m;
    assign hr  = mode12 ? w_hr12 : r_h24;
    assign pm  = (r_h24 >= 8'h12);
    assign day = r_day;

`ifdef ALARM_EN
    logic r_alarm;
    logic w_alarm_valid;

    // The state is always valid BCD, so rejecting bad compare values only guards the equality.
    assign w_alarm_valid = (alarm_hr[3:0] <= 4'd9) && (alarm_hr <= 8'h23) &&
                           (alarm_min[3:0] <= 4'd9) && (alarm_min[7:4] <= 4'd5);

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            r_alarm <= 1'b0;
        else
            r_alarm <= alarm_on && w_alarm_valid && (r_h24 == alarm_hr) && (r_m == alarm_min);
    end

    assign alarm = r_alarm;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// tb/tb_bcd_time_counter.sv - scoreboard bench for bcd_time_counter (TICK_DIV=4, SYNC_STAGES=2)
module tb_bcd_time_counter;

    logic       clk = 1'b0;
    logic       clr, tick, hold, mode12, inc_min, inc_hr;
    logic [7:0] sec, min, hr;
    logic       pm, day;
`ifdef ALARM_EN
    logic       alarm_on;
    logic [7:0] alarm_hr, alarm_min;
    logic       alarm;
`endif

    typedef struct {
        string      name;
        logic [7:0] h, m, s;
        logic       pm, day, al;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    bcd_time_counter #(.TICK_DIV(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .clr(clr), .tick(tick), .hold(hold), .mode12(mode12),
        .inc_min(inc_min), .inc_hr(inc_hr),
`ifdef ALARM_EN
        .alarm_on(alarm_on), .alarm_hr(alarm_hr), .alarm_min(alarm_min), .alarm(alarm),
`endif
        .sec(sec), .min(min), .hr(hr), .pm(pm), .day(day)
    );

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic al_act;
            e = q.pop_front();
`ifdef ALARM_EN
            al_act = alarm;
`else
            al_act = e.al;
`endif
            n_tests++;
            if (hr !== e.h || min !== e.m || sec !== e.s || pm !== e.pm || day !== e.day || al_act !== e.al) begin
                n_fail++;
                $display("FAIL %s: got %02h:%02h:%02h pm=%0b day=%0b alarm=%0b, want %02h:%02h:%02h pm=%0b day=%0b alarm=%0b",
                         e.name, hr, min, sec, pm, day, al_act, e.h, e.m, e.s, e.pm, e.day, e.al);
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] eh, input logic [7:0] em, input logic [7:0] es,
                       input logic epm, input logic eday, input logic eal = 1'b0);
        exp_t e;
        e.name = nm; e.h = eh; e.m = em; e.s = es; e.pm = epm; e.day = eday; e.al = eal;
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    task automatic press_min(input int n);
        repeat (n) begin
            inc_min = 1'b1;
            repeat (3) step();
            inc_min = 1'b0;
            repeat (3) step();
        end
    endtask

    task automatic press_hr(input int n);
        repeat (n) begin
            inc_hr = 1'b1;
            repeat (3) step();
            inc_hr = 1'b0;
            repeat (3) step();
        end
    endtask

    task automatic do_reset();
        step();
        clr = 1'b1;
        repeat (2) step();
        clr = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1; tick = 1'b0; hold = 1'b0; mode12 = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
`ifdef ALARM_EN
        alarm_on = 1'b0; alarm_hr = 8'h00; alarm_min = 8'h00;
`endif
        #1;
        chk("reset_24h", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        mode12 = 1'b1;
        chk("reset_12h", 8'h12, 8'h00, 8'h00, 1'b0, 1'b0);
        mode12 = 1'b0;
        step();
        clr = 1'b0;
        repeat (4) step();

        // Reach 14:27:33 then clear asynchronously in 12-hour mode.
        press_hr(14);
        press_min(27);
        chk("set_14_27", 8'h14, 8'h27, 8'h00, 1'b1, 1'b0);
        ticks(33 * 4);
        chk("run_14_27_33", 8'h14, 8'h27, 8'h33, 1'b1, 1'b0);
        mode12 = 1'b1;
        chk("mode12_14", 8'h02, 8'h27, 8'h33, 1'b1, 1'b0);
        step();
        clr = 1'b1;
        #1;
        chk("async_clr", 8'h12, 8'h00, 8'h00, 1'b0, 1'b0);
        step();
        clr = 1'b0;
        mode12 = 1'b0;
        repeat (4) step();

        // Long inc_min press at 10:59:42 with pcnt=2.
        press_hr(10);
        press_min(59);
        ticks(42 * 4 + 2);
        chk("pre_10_59_42", 8'h10, 8'h59, 8'h42, 1'b0, 1'b0);
        inc_min = 1'b1;
        step(); step();
        chk("btn_edge2", 8'h10, 8'h59, 8'h42, 1'b0, 1'b0);
        step();
        chk("btn_edge3", 8'h10, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (96) step();
        chk("btn_held", 8'h10, 8'h00, 8'h00, 1'b0, 1'b0);
        inc_min = 1'b0;
        repeat (3) step();
        ticks(3);
        chk("pcnt_cleared", 8'h10, 8'h00, 8'h00, 1'b0, 1'b0);
        ticks(1);
        chk("first_sec", 8'h10, 8'h00, 8'h01, 1'b0, 1'b0);

        // Hour button wraps 23 -> 00 without touching minutes.
        press_min(1);
        press_hr(13);
        chk("hr_23", 8'h23, 8'h01, 8'h00, 1'b1, 1'b0);
        press_hr(1);
        chk("hr_wrap", 8'h00, 8'h01, 8'h00, 1'b0, 1'b0);

        // inc_min edge coincident with a tick at 08:15:20 (pcnt=1).
        press_hr(8);
        press_min(14);
        ticks(20 * 4 + 1);
        chk("pre_08_15_20", 8'h08, 8'h15, 8'h20, 1'b0, 1'b0);
        inc_min = 1'b1;
        step(); step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("coincide", 8'h08, 8'h16, 8'h00, 1'b0, 1'b0);
        inc_min = 1'b0;
        repeat (3) step();
        ticks(3);
        chk("dropped_tick", 8'h08, 8'h16, 8'h00, 1'b0, 1'b0);
        ticks(1);
        chk("after_coincide", 8'h08, 8'h16, 8'h01, 1'b0, 1'b0);
        ticks(2);
        hold = 1'b1;
        ticks(8);
        chk("hold", 8'h08, 8'h16, 8'h01, 1'b0, 1'b0);
        hold = 1'b0;
        ticks(2);
        chk("hold_pcnt_kept", 8'h08, 8'h16, 8'h02, 1'b0, 1'b0);

        // Midnight rollover with prescaler and 12-hour display.
        do_reset();
        press_hr(23);
        press_min(59);
        ticks(59 * 4);
        mode12 = 1'b1;
        chk("h23_12h", 8'h11, 8'h59, 8'h59, 1'b1, 1'b0);
        ticks(3);
        chk("three_ticks", 8'h11, 8'h59, 8'h59, 1'b1, 1'b0);
        ticks(1);
        chk("day_roll", 8'h12, 8'h00, 8'h00, 1'b0, 1'b1);
        step();
        chk("day_clear", 8'h12, 8'h00, 8'h00, 1'b0, 1'b0);
        mode12 = 1'b0;
        chk("h00_24h", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        press_hr(12);
        mode12 = 1'b1;
        chk("h12_12h", 8'h12, 8'h00, 8'h00, 1'b1, 1'b0);
        press_hr(1);
        press_min(5);
        chk("h13_12h", 8'h01, 8'h05, 8'h00, 1'b1, 1'b0);
        mode12 = 1'b0;
        chk("h13_24h", 8'h13, 8'h05, 8'h00, 1'b1, 1'b0);

`ifdef ALARM_EN
        do_reset();
        alarm_hr = 8'h06; alarm_min = 8'h30; alarm_on = 1'b1;
        press_hr(6);
        press_min(29);
        ticks(59 * 4);
        chk("al_pre", 8'h06, 8'h29, 8'h59, 1'b0, 1'b0, 1'b0);
        ticks(4);
        chk("al_0630_edge", 8'h06, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0);
        step();
        chk("al_rise", 8'h06, 8'h30, 8'h00, 1'b0, 1'b0, 1'b1);
        ticks(240);
        chk("al_0631_edge", 8'h06, 8'h31, 8'h00, 1'b0, 1'b0, 1'b1);
        step();
        chk("al_fall", 8'h06, 8'h31, 8'h00, 1'b0, 1'b0, 1'b0);
        alarm_min = 8'h3A;
        press_min(9);
        step();
        chk("al_bad_bcd", 8'h06, 8'h40, 8'h00, 1'b0, 1'b0, 1'b0);
`endif

        begin
            int k;
            k = 0;
            while (q.size() > 0 && k < 10) begin
                @(negedge clk);
                k++;
            end
            if (q.size() > 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL drain: %0d expectations left, want 0", q.size());
            end
        end
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
